// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and load/store share one RAM port,
// with alternating priority on ties, a wait timeout and one-cycle completion pulses.
module mem_arbiter #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_i,
    input  logic [XLEN-1:0] if_addr_i,
    output logic [XLEN-1:0] if_rdata_o,
    output logic            if_done_o,

    input  logic            mem_req_i,
    input  logic            mem_we_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_wdata_i,
    input  logic [7:0]      mem_wmask_i,
    output logic [XLEN-1:0] mem_rdata_o,
    output logic            mem_done_o,

    output logic            ram_stall_valid_if_o,
    output logic            ram_stall_valid_mem_o,

    output logic            ram_req_o,
    output logic            ram_we_o,
    output logic [XLEN-1:0] ram_addr_o,
    output logic [XLEN-1:0] ram_wdata_o,
    output logic [7:0]      ram_wmask_o,
    input  logic            ram_ack_i,
    input  logic [XLEN-1:0] ram_rdata_i,

    output logic            bus_err_o
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned MASK_W = 8;
    localparam logic        GRANT_IF  = 1'b0;
    localparam logic        GRANT_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_WAIT  = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [XLEN-1:0]     if_rdata_q, if_rdata_d;
    logic [XLEN-1:0]     mem_rdata_q, mem_rdata_d;
    logic                ram_req_q, ram_req_d;
    logic                if_done_q, if_done_d;
    logic                mem_done_q, mem_done_d;
    logic                bus_err_q, bus_err_d;
    logic                finish_c;
    logic                timeout_c;
    logic [XLEN-1:0]     resp_data_c;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            last_q      <= GRANT_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            ram_req_q   <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            ram_req_q   <= ram_req_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Next-state: grant in IDLE, wait for ack or timeout, one-cycle response
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        bus_err_d   = 1'b0;
        finish_c    = 1'b0;
        timeout_c   = 1'b0;
        resp_data_c = '0;

        case (state_q)
            IDLE: begin
                if (mem_req_i && (!if_req_i || last_q == GRANT_IF)) begin
                    state_d = MEM_WAIT;
                    cnt_d   = '0;
                    we_d    = mem_we_i;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    wmask_d = mem_wmask_i;
                end else if (if_req_i) begin
                    state_d = IF_WAIT;
                    cnt_d   = '0;
                    we_d    = 1'b0;
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                    wmask_d = '0;
                end
            end
            IF_WAIT, MEM_WAIT: begin
                if (ram_ack_i) begin
                    finish_c    = 1'b1;
                    resp_data_c = ram_rdata_i;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    finish_c  = 1'b1;
                    timeout_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion: load owner's read data (never on a store) and schedule pulses
        if (finish_c) begin
            state_d   = RESP;
            bus_err_d = timeout_c;
            if (state_q == MEM_WAIT) begin
                last_d     = GRANT_MEM;
                mem_done_d = 1'b1;
                if (!we_q) begin
                    mem_rdata_d = resp_data_c;
                end
            end else begin
                last_d     = GRANT_IF;
                if_done_d  = 1'b1;
                if_rdata_d = resp_data_c;
            end
        end

        ram_req_d = (state_d == IF_WAIT) || (state_d == MEM_WAIT);
    end

    assign if_rdata_o   = if_rdata_q;
    assign if_done_o    = if_done_q;
    assign mem_rdata_o  = mem_rdata_q;
    assign mem_done_o   = mem_done_q;
    assign ram_req_o    = ram_req_q;
    assign ram_we_o     = we_q;
    assign ram_addr_o   = addr_q;
    assign ram_wdata_o  = wdata_q;
    assign ram_wmask_o  = wmask_q;
    assign bus_err_o    = bus_err_q;

    // Stall requests go to the hazard unit combinationally
    assign ram_stall_valid_if_o  = if_req_i & ~if_done_q;
    assign ram_stall_valid_mem_o = mem_req_i & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned XLEN = 64;
    localparam int          TMO  = 4;
    localparam logic [63:0] MEM_ADDR6 = 64'h0000_0000_0000_A000;
    localparam logic [63:0] IF_ADDR6  = 64'h0000_0000_0000_B000;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            if_req = 1'b0;
    logic [XLEN-1:0] if_addr = '0;
    logic [XLEN-1:0] if_rdata;
    logic            if_done;
    logic            mem_req = 1'b0;
    logic            mem_we = 1'b0;
    logic [XLEN-1:0] mem_addr = '0;
    logic [XLEN-1:0] mem_wdata = '0;
    logic [7:0]      mem_wmask = '0;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_done;
    logic            stall_if;
    logic            stall_mem;
    logic            ram_req;
    logic            ram_we;
    logic [XLEN-1:0] ram_addr;
    logic [XLEN-1:0] ram_wdata;
    logic [7:0]      ram_wmask;
    logic            ram_ack = 1'b0;
    logic [XLEN-1:0] ram_rdata = '0;
    logic            bus_err;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(TMO)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .if_req_i              (if_req),
        .if_addr_i             (if_addr),
        .if_rdata_o            (if_rdata),
        .if_done_o             (if_done),
        .mem_req_i             (mem_req),
        .mem_we_i              (mem_we),
        .mem_addr_i            (mem_addr),
        .mem_wdata_i           (mem_wdata),
        .mem_wmask_i           (mem_wmask),
        .mem_rdata_o           (mem_rdata),
        .mem_done_o            (mem_done),
        .ram_stall_valid_if_o  (stall_if),
        .ram_stall_valid_mem_o (stall_mem),
        .ram_req_o             (ram_req),
        .ram_we_o              (ram_we),
        .ram_addr_o            (ram_addr),
        .ram_wdata_o           (ram_wdata),
        .ram_wmask_o           (ram_wmask),
        .ram_ack_i             (ram_ack),
        .ram_rdata_i           (ram_rdata),
        .bus_err_o             (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one transaction in flight, a response cycle, alternating ties
    logic            m_busy, m_is_mem, m_resp, m_resp_mem, m_err, m_last_mem;
    int              m_waited;
    logic            m_we;
    logic [XLEN-1:0] m_addr, m_wdata, m_if_rdata, m_mem_rdata;
    logic [7:0]      m_wmask;
    logic            m_take_mem;

    assign m_take_mem = mem_req && !(if_req && m_last_mem);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 1'b0; m_is_mem <= 1'b0; m_resp <= 1'b0; m_resp_mem <= 1'b0;
            m_err <= 1'b0; m_last_mem <= 1'b0; m_waited <= 0;
            m_we <= 1'b0; m_addr <= '0; m_wdata <= '0; m_wmask <= '0;
            m_if_rdata <= '0; m_mem_rdata <= '0;
        end else if (m_resp) begin
            m_resp <= 1'b0;
            m_err  <= 1'b0;
        end else if (m_busy) begin
            if (ram_ack || (m_waited + 1 == TMO)) begin
                m_busy     <= 1'b0;
                m_resp     <= 1'b1;
                m_resp_mem <= m_is_mem;
                m_err      <= !ram_ack;
                m_last_mem <= m_is_mem;
                if (!m_is_mem) m_if_rdata <= ram_ack ? ram_rdata : '0;
                else if (!m_we) m_mem_rdata <= ram_ack ? ram_rdata : '0;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else if (if_req || mem_req) begin
            m_busy   <= 1'b1;
            m_is_mem <= m_take_mem;
            m_waited <= 0;
            m_we     <= m_take_mem ? mem_we : 1'b0;
            m_addr   <= m_take_mem ? mem_addr : if_addr;
            m_wdata  <= m_take_mem ? mem_wdata : '0;
            m_wmask  <= m_take_mem ? mem_wmask : 8'h00;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            chk("ram_req", 64'(ram_req), 64'(m_busy));
            chk("if_done", 64'(if_done), 64'(m_resp && !m_resp_mem));
            chk("mem_done", 64'(mem_done), 64'(m_resp && m_resp_mem));
            chk("bus_err", 64'(bus_err), 64'(m_resp && m_err));
            chk("if_rdata", if_rdata, m_if_rdata);
            chk("mem_rdata", mem_rdata, m_mem_rdata);
            chk("stall_if", 64'(stall_if), 64'(if_req && !(m_resp && !m_resp_mem)));
            chk("stall_mem", 64'(stall_mem), 64'(mem_req && !(m_resp && m_resp_mem)));
            if (m_busy) begin
                chk("ram_we", 64'(ram_we), 64'(m_we));
                chk("ram_addr", ram_addr, m_addr);
                chk("ram_wdata", ram_wdata, m_wdata);
                chk("ram_wmask", 64'(ram_wmask), 64'(m_wmask));
            end
        end
    end

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    logic grants[$];
    logic prev_req;

    initial begin
        // Reset state
        step(); step();
        chk("rst_ram_req", 64'(ram_req), 64'd0);
        chk("rst_ram_we", 64'(ram_we), 64'd0);
        chk("rst_ram_addr", ram_addr, 64'd0);
        chk("rst_if_done", 64'(if_done), 64'd0);
        chk("rst_mem_done", 64'(mem_done), 64'd0);
        chk("rst_bus_err", 64'(bus_err), 64'd0);
        chk("rst_if_rdata", if_rdata, 64'd0);
        chk("rst_mem_rdata", mem_rdata, 64'd0);
        rst = 1'b1;
        step();

        // IF read, ack one cycle after the request reaches the RAM
        if_req = 1'b1; if_addr = 64'h8000_0000;
        chk("t1_req_idle", 64'(ram_req), 64'd0);
        step();
        chk("t1_req_t1", 64'(ram_req), 64'd1);
        chk("t1_addr", ram_addr, 64'h8000_0000);
        step();
        chk("t1_req_t2", 64'(ram_req), 64'd1);
        ram_ack = 1'b1; ram_rdata = 64'h13;
        step();
        ram_ack = 1'b0; if_req = 1'b0;
        chk("t1_done", 64'(if_done), 64'd1);
        chk("t1_rdata", if_rdata, 64'h13);
        chk("t1_req_resp", 64'(ram_req), 64'd0);
        step();
        chk("t1_done_off", 64'(if_done), 64'd0);

        // Simultaneous requests straight after reset: MEM first
        rst = 1'b0; step(); rst = 1'b1; step();
        if_req = 1'b1; if_addr = 64'h1000;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h2000; mem_wmask = 8'hFF;
        step();
        chk("t2_first_addr", ram_addr, 64'h2000);
        chk("t2_stall_if_a", 64'(stall_if), 64'd1);
        ram_ack = 1'b1; ram_rdata = 64'hAAAA;
        step();
        ram_ack = 1'b0; mem_req = 1'b0;
        chk("t2_mem_done", 64'(mem_done), 64'd1);
        chk("t2_mem_rdata", mem_rdata, 64'hAAAA);
        chk("t2_stall_if_b", 64'(stall_if), 64'd1);
        step();
        chk("t2_idle_req", 64'(ram_req), 64'd0);
        chk("t2_stall_if_c", 64'(stall_if), 64'd1);
        step();
        chk("t2_second_addr", ram_addr, 64'h1000);
        ram_ack = 1'b1; ram_rdata = 64'hBBBB;
        step();
        ram_ack = 1'b0; if_req = 1'b0;
        chk("t2_if_done", 64'(if_done), 64'd1);
        chk("t2_if_rdata", if_rdata, 64'hBBBB);
        step();

        // Store, flushed by the requester, still completes without touching mem_rdata
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h3000;
        mem_wdata = 64'hDEAD_BEEF; mem_wmask = 8'h0F;
        step();
        mem_req = 1'b0; mem_we = 1'b0; mem_wdata = '0; mem_wmask = '0;
        chk("t3_we", 64'(ram_we), 64'd1);
        chk("t3_wdata", ram_wdata, 64'hDEAD_BEEF);
        chk("t3_wmask", 64'(ram_wmask), 64'h0F);
        step();
        chk("t3_we_hold", 64'(ram_we), 64'd1);
        chk("t3_addr_hold", ram_addr, 64'h3000);
        ram_ack = 1'b1; ram_rdata = 64'h5555;
        step();
        ram_ack = 1'b0;
        chk("t3_done", 64'(mem_done), 64'd1);
        chk("t3_rdata_kept", mem_rdata, 64'hAAAA);
        step();

        // Timeout: no ack for TMO wait cycles, then stray acks are ignored
        mem_req = 1'b1; mem_addr = 64'h4000; mem_wmask = 8'hFF;
        for (int i = 0; i < TMO; i++) begin
            step();
            chk("t4_waiting", 64'(ram_req), 64'd1);
        end
        step();
        mem_req = 1'b0; ram_ack = 1'b1; ram_rdata = 64'h9999;
        chk("t4_bus_err", 64'(bus_err), 64'd1);
        chk("t4_done", 64'(mem_done), 64'd1);
        chk("t4_rdata_zero", mem_rdata, 64'd0);
        step();
        chk("t4_err_off", 64'(bus_err), 64'd0);
        chk("t4_stray_req", 64'(ram_req), 64'd0);
        step();
        ram_ack = 1'b0;
        chk("t4_stray_rdata", mem_rdata, 64'd0);

        // Reset during MEM_WAIT drops the request at once, then IF works normally
        mem_req = 1'b1; mem_addr = 64'h5000;
        step();
        chk("t5_wait", 64'(ram_req), 64'd1);
        step();
        rst = 1'b0; mem_req = 1'b0;
        #1;
        chk("t5_async_drop", 64'(ram_req), 64'd0);
        chk("t5_no_done", 64'(mem_done), 64'd0);
        step();
        chk("t5_no_done2", 64'(mem_done), 64'd0);
        rst = 1'b1;
        step();
        if_req = 1'b1; if_addr = 64'h6000;
        step();
        chk("t5_if_addr", ram_addr, 64'h6000);
        ram_ack = 1'b1; ram_rdata = 64'h77;
        step();
        ram_ack = 1'b0; if_req = 1'b0;
        chk("t5_if_done", 64'(if_done), 64'd1);
        chk("t5_if_rdata", if_rdata, 64'h77);
        step();

        // Continuous MEM traffic with IF pending: grants alternate, MEM first
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = MEM_ADDR6;
        if_req = 1'b1; if_addr = IF_ADDR6;
        prev_req = 1'b0;
        for (int c = 0; c < 24; c++) begin
            step();
            ram_ack = ram_req;
            ram_rdata = 64'h100 + 64'(c);
            if (ram_req && !prev_req) grants.push_back(ram_addr == MEM_ADDR6);
            prev_req = ram_req;
        end
        mem_req = 1'b0; if_req = 1'b0; ram_ack = 1'b0;
        chk("t6_grant_count", 64'(grants.size() >= 6), 64'd1);
        for (int g = 0; g < 6; g++) begin
            chk("t6_alternate", 64'(grants[g]), 64'((g % 2) == 0));
        end
        step(); step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 64, address and data width.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for ram_ack_i (1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 SHALL have ports if_req_i  input  1, if_addr_i  input  XLEN  instruction-fetch read request and address.
REQ-006 SHALL have ports if_rdata_o  output  XLEN, if_done_o  output  1  fetch read data and one-cycle completion pulse.
REQ-007 SHALL have ports mem_req_i  input  1, mem_we_i  input  1, mem_addr_i  input  XLEN, mem_wdata_i  input  XLEN, mem_wmask_i  input  8  load/store request.
REQ-008 SHALL have ports mem_rdata_o  output  XLEN, mem_done_o  output  1  load data and one-cycle completion pulse.
REQ-009 SHALL have ports ram_stall_valid_if_o  output  1, ram_stall_valid_mem_o  output  1  stall requests to the hazard/trap controller.
REQ-010 SHALL have ports ram_req_o  output  1, ram_we_o  output  1, ram_addr_o  output  XLEN, ram_wdata_o  output  XLEN, ram_wmask_o  output  8  shared memory port.
REQ-011 SHALL have ports ram_ack_i  input  1, ram_rdata_i  input  XLEN  memory completion and read data.
REQ-012 SHALL have port bus_err_o  output  1  one-cycle pulse on timeout completion.

Function
REQ-013 SHALL implement states IDLE, IF_WAIT, MEM_WAIT, RESP.
REQ-014 In IDLE with only mem_req_i=1, SHALL latch mem_we/addr/wdata/wmask and go to MEM_WAIT; only if_req_i=1, SHALL latch if_addr_i with we=0, wmask=0, and go to IF_WAIT.
REQ-015 In IDLE with both requests high, SHALL grant the port not granted last; last-grant register resets to IF, so the first tie goes to MEM.
REQ-016 In IF_WAIT/MEM_WAIT, SHALL drive ram_req_o=1 with latched fields held stable until the cycle ram_ack_i=1 is sampled.
REQ-017 On ram_ack_i=1 in a WAIT state, SHALL register ram_rdata_i into the owning port's rdata_o, update last-grant, and go to RESP.
REQ-018 In RESP, SHALL assert the owning port's done_o for exactly one cycle, issue no grant, and return to IDLE.
REQ-019 Minimum latency: request seen in IDLE at cycle T, ram_req_o high at T+1, ack at T+1, done_o at T+2.
REQ-020 ram_stall_valid_p_o SHALL equal p_req_i & ~p_done_o, combinationally, for p in {if, mem}.
REQ-021 rdata_o SHALL hold its value until the next completion of the same port; writes SHALL not modify mem_rdata_o.
REQ-022 A wait counter SHALL clear on entering a WAIT state and increment each WAIT cycle without ack; when it reaches TIMEOUT, SHALL go to RESP with rdata_o loaded as 0 and bus_err_o=1 in the RESP cycle.
REQ-023 ram_ack_i outside WAIT states SHALL be ignored.
REQ-024 A requester dropping req mid-transaction (flush) SHALL NOT abort it; the access completes and done_o still pulses.
REQ-025 ram_req_o SHALL be 0 in IDLE and RESP.

Reset
REQ-026 When rst=0, SHALL asynchronously enter IDLE; clear the counter, last-grant=IF, rdata_o=0, and done_o, bus_err_o, ram_req_o, ram_we_o=0; latched fields=0.
REQ-027 Reset mid-WAIT SHALL drop ram_req_o in the same cycle with no done_o pulse; the first request after release starts from IDLE.

Verification
REQ-028 IF read addr 0x80000000, ack one cycle later with rdata 0x13 -> ram_req_o cycles T+1..T+2, if_done_o at T+3, if_rdata_o=0x13.
REQ-029 Both requests at the same cycle after reset -> MEM granted first; IF granted after RESP; stall_if held high throughout.
REQ-030 Store mem_we=1, wmask=0x0F, wdata=0xDEADBEEF -> ram_we_o=1 and fields stable until ack; mem_rdata_o unchanged.
REQ-031 No ack with TIMEOUT=4 -> RESP after 4 WAIT cycles; bus_err_o and mem_done_o pulse together; mem_rdata_o=0.
REQ-032 rst=0 during MEM_WAIT -> ram_req_o=0 immediately; no done_o pulse; the next IF request completes normally.
REQ-033 Back-to-back MEM requests with IF pending -> IF served between them (alternation), never starved.
